// File: rtl/regfile_dump.sv
// Register-file dump engine: walks [first_addr, last_addr] through one combinational
// read port and streams (address, data) pairs on a valid/ready interface.
// Optional: define REGDUMP_CHECKSUM_EN to add an XOR checksum output over consumed words.
module regfile_dump #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [XLEN-1:0]   rf_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [XLEN-1:0]   out_data,
    output logic              busy,
    output logic              done
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [XLEN-1:0]   checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        HOLD,
        DONE
    } state_t;

    // One extra bit so NUM_REGS itself is representable in the range check.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [ADDR_W-1:0] end_reg, end_next;
    logic              out_valid_reg, out_valid_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic [XLEN-1:0]   out_data_reg, out_data_next;
    logic              range_ok;
    logic              handshake;

    assign range_ok  = (first_addr <= last_addr) && ({1'b0, last_addr} < NUM_REGS_W);
    assign handshake = (state_reg == HOLD) && out_ready;

`ifdef REGDUMP_CHECKSUM_EN
    logic [XLEN-1:0] checksum_reg, checksum_next;

    always_comb begin
        checksum_next = checksum_reg;
        if (state_reg == IDLE && start) begin
            checksum_next = '0;
        end else if (handshake) begin
            // A word consumed in the same cycle as abort still folds in.
            checksum_next = checksum_reg ^ out_data_reg
                          ^ {{(XLEN - ADDR_W){1'b0}}, out_addr_reg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_reg <= '0;
        end else begin
            checksum_reg <= checksum_next;
        end
    end

    assign checksum = checksum_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        end_next       = end_reg;
        out_valid_next = out_valid_reg;
        out_addr_next  = out_addr_reg;
        out_data_next  = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    idx_next   = first_addr;
                    end_next   = last_addr;
                    state_next = range_ok ? READ : DONE;
                end
            end
            READ: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    out_data_next  = rf_rd;
                    out_addr_next  = idx_reg;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (idx_reg == end_reg) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + ADDR_W'(1);
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            end_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            end_reg       <= end_next;
            out_valid_reg <= out_valid_next;
            out_addr_reg  <= out_addr_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign rf_ra     = (state_reg == IDLE) ? '0 : idx_reg;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: expected words are queued at start and
// compared as the DUT hands them over. Define REGDUMP_CHECKSUM_EN to cover the checksum.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] rf_mem [32];

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    word_t sb[$];

    int check_count = 0;
    int error_count = 0;
    int done_seen   = 0;

    always #5 clk = ~clk;

    assign rf_rd = (rf_ra == 5'd0) ? 32'd0 : rf_mem[rf_ra];

    regfile_dump #(
        .XLEN    (32),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .rf_ra     (rf_ra),
        .rf_rd     (rf_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
`ifdef REGDUMP_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++) begin
            word_t w;
            w.a = 5'(i);
            w.d = (i == 0) ? 32'd0 : rf_mem[i];
            sb.push_back(w);
        end
    endtask

    task automatic do_start(input int f, input int l);
        first_addr = 5'(f);
        last_addr  = 5'(l);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // cyc counts edges since start was presented; the start-sampling edge is 1.
    task automatic wait_done(input int stall, input bit poke, output int cyc, output int fv);
        int sc;
        cyc = 1;
        fv  = 0;
        sc  = 0;
        while (!done && cyc < 400) begin
            if (stall > 0) begin
                if (out_valid && sc < stall) begin
                    out_ready = 1'b0;
                    sc++;
                end else begin
                    out_ready = 1'b1;
                    if (out_valid) sc = 0;
                end
            end
            if (poke && cyc == 3) begin
                first_addr = 5'd20;
                last_addr  = 5'd20;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
            if (out_valid && fv == 0) fv = cyc;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Consumer-side monitor: scoreboard pops, hold stability, done pulses.
    bit          hold_prev = 1'b0;
    logic [4:0]  held_addr;
    logic [31:0] held_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (done) done_seen++;
            if (hold_prev && out_valid) begin
                check("hold_addr", 32'(out_addr), 32'(held_addr));
                check("hold_data", out_data, held_data);
            end
            hold_prev = out_valid && !out_ready;
            held_addr = out_addr;
            held_data = out_data;
            if (out_valid && out_ready) begin
                $display("word addr=%0d data=%08h", out_addr, out_data);
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'(out_addr), 32'hffff_ffff);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    check("word_addr", 32'(out_addr), 32'(w.a));
                    check("word_data", out_data, w.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, fv, d0, n;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = 5'd0;
        last_addr  = 5'd0;
        out_ready  = 1'b1;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i);

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_ra", 32'(rf_ra), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full dump at full throughput.
        d0 = done_seen;
        push_range(0, 31);
        do_start(0, 31);
        check("full_busy", 32'(busy), 32'd1);
        check("full_read_valid", 32'(out_valid), 32'd0);
        wait_done(0, 1'b0, cyc, fv);
        check("full_first_valid", 32'(fv), 32'd2);
        check("full_done_edge", 32'(cyc), 32'd65);
        check("full_done_busy", 32'(busy), 32'd1);
        tick();
        check("full_done_count", 32'(done_seen - d0), 32'd1);
        check("full_idle_busy", 32'(busy), 32'd0);
        check("full_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure, with an ignored start while busy.
        d0 = done_seen;
        push_range(5, 7);
        do_start(5, 7);
        wait_done(3, 1'b1, cyc, fv);
        tick();
        check("bp_done_count", 32'(done_seen - d0), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Single-word dump at the top register.
        push_range(31, 31);
        do_start(31, 31);
        wait_done(0, 1'b0, cyc, fv);
        check("single_done_edge", 32'(cyc), 32'd3);
        tick();
        check("single_sb_empty", 32'(sb.size()), 32'd0);

        // Empty range: straight to DONE, no words.
        d0 = done_seen;
        do_start(9, 3);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd1);
        check("empty_valid", 32'(out_valid), 32'd0);
        tick();
        check("empty_done_low", 32'(done), 32'd0);
        check("empty_busy_low", 32'(busy), 32'd0);
        check("empty_done_count", 32'(done_seen - d0), 32'd1);

        // Abort while word 4 is held.
        d0 = done_seen;
        push_range(0, 31);
        do_start(0, 31);
        n = 0;
        while (!(out_valid && out_addr == 5'd4) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_w4", 32'(n < 100), 32'd1);
        abort     = 1'b1;
        out_ready = 1'b0;
        tick();
        abort     = 1'b0;
        out_ready = 1'b1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_remaining", 32'(sb.size()), 32'd28);
        sb.delete();
        tick();
        check("abort_no_done", 32'(done_seen - d0), 32'd0);
        push_range(30, 31);
        do_start(30, 31);
        wait_done(0, 1'b0, cyc, fv);
        tick();
        check("post_abort_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset in HOLD.
        d0 = done_seen;
        out_ready = 1'b0;
        do_start(0, 31);
        tick();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_rf_ra", 32'(rf_ra), 32'd0);
        check("areset_addr", 32'(out_addr), 32'd0);
        check("areset_data", out_data, 32'd0);
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_no_done", 32'(done_seen - d0), 32'd0);

`ifdef REGDUMP_CHECKSUM_EN
        push_range(1, 3);
        do_start(1, 3);
        wait_done(0, 1'b0, cyc, fv);
        check("csum_identity", checksum, 32'd0);
        tick();
        for (int i = 1; i <= 3; i++) rf_mem[i] = 32'hA5A5_0000;
        push_range(1, 3);
        do_start(1, 3);
        wait_done(0, 1'b0, cyc, fv);
        check("csum_pattern", checksum, 32'hA5A5_0000);
        tick();
        check("csum_stable", checksum, 32'hA5A5_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
